// File: rtl/lut_neuron_array_prog.sv
// lut_neuron_array_prog: NEURONS parallel LUT neurons whose truth tables live in
// distributed RAM. The tables are loaded through a serial config port. Evaluation
// runs in a 2-stage valid/ready pipeline (stage 1 registers the input word, stage 2
// reads the tables and registers the result).
// Optional build macro LUT_PARITY_EN adds a stored even-parity bit per entry and a
// sticky parity_err output.
//
// state | meaning
// EMPTY | no table loaded, inputs refused
// LOAD  | accepting table writes, pipeline empty
// DRAIN | a write arrived mid-stream; flushing the pipeline, write held pending
// RUN   | evaluating input words
module lut_neuron_array_prog #(
  parameter int NEURONS  = 4,
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int NIDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [NIDX_W-1:0]            cfg_neuron,
  input  logic [IN_BITS-1:0]           cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  input  logic                         cfg_last,
  output logic                         cfg_busy,
  output logic                         configured,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NEURONS*IN_BITS-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data
`ifdef LUT_PARITY_EN
  ,output logic                        parity_err
`endif
);

  localparam int DEPTH = 1 << IN_BITS;
`ifdef LUT_PARITY_EN
  localparam int RAM_W = OUT_BITS + 1;
`else
  localparam int RAM_W = OUT_BITS;
`endif

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_DRAIN, S_RUN} state_t;

  state_t                       state;
  logic                         pend_valid;
  logic [NIDX_W-1:0]            pend_neuron;
  logic [IN_BITS-1:0]           pend_addr;
  logic [OUT_BITS-1:0]          pend_data;
  logic                         pend_last;

  logic                         s1_valid;
  logic [NEURONS*IN_BITS-1:0]   s1_data;
  logic                         s2_valid;
  logic                         s1_advance;
  logic                         pipe_empty;
  logic                         in_fire;

  logic                         wr_sel;
  logic                         wr_en;
  logic [NIDX_W-1:0]            wr_neuron;
  logic [IN_BITS-1:0]           wr_addr;
  logic [OUT_BITS-1:0]          wr_data;
  logic [RAM_W-1:0]             wr_word;

  logic [RAM_W-1:0]             tbl [NEURONS][DEPTH];
  logic [RAM_W-1:0]             rd_word [NEURONS];
  logic [NEURONS*OUT_BITS-1:0]  rd_out;

  assign s1_advance = !s2_valid || out_ready;
  assign pipe_empty = !s1_valid && !s2_valid;
  assign in_ready   = (state == S_RUN) && !cfg_we && (!s1_valid || s1_advance);
  assign in_fire    = in_valid && in_ready;
  assign out_valid  = s2_valid;
  assign cfg_busy   = (state == S_LOAD) || (state == S_DRAIN);

  // Select the write source: the live config port, or the pending write once drained.
  always_comb begin
    wr_sel    = 1'b0;
    wr_neuron = cfg_neuron;
    wr_addr   = cfg_addr;
    wr_data   = cfg_data;
    case (state)
      S_EMPTY, S_LOAD: wr_sel = cfg_we;
      S_RUN:           wr_sel = cfg_we && pipe_empty;
      S_DRAIN: begin
        if (pipe_empty && pend_valid) begin
          wr_sel    = 1'b1;
          wr_neuron = pend_neuron;
          wr_addr   = pend_addr;
          wr_data   = pend_data;
        end
      end
      default: ;
    endcase
    // Out-of-range neuron selects perform no write but still count for sequencing.
    wr_en = wr_sel && (int'(wr_neuron) < NEURONS);
  end

`ifdef LUT_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Table RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) tbl[wr_neuron][wr_addr] <= wr_word;
  end

  // Asynchronous table read of every neuron at its stage-1 address.
  always_comb begin
    rd_out = '0;
    for (int n = 0; n < NEURONS; n++) begin
      rd_word[n] = tbl[n][s1_data[n*IN_BITS +: IN_BITS]];
      rd_out[n*OUT_BITS +: OUT_BITS] = rd_word[n][OUT_BITS-1:0];
    end
  end

`ifdef LUT_PARITY_EN
  logic rd_par_bad;

  // A stored entry {parity, data} XORs to zero when intact.
  always_comb begin
    rd_par_bad = 1'b0;
    for (int n = 0; n < NEURONS; n++) rd_par_bad = rd_par_bad | (^rd_word[n]);
  end

  // Sticky parity error, raised together with the affected result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    parity_err <= 1'b0;
    else if (s1_advance && s1_valid && rd_par_bad) parity_err <= 1'b1;
  end
`endif

  // Config sequencing FSM; writes only land while the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      configured  <= 1'b0;
      pend_valid  <= 1'b0;
      pend_neuron <= '0;
      pend_addr   <= '0;
      pend_data   <= '0;
      pend_last   <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (cfg_we) begin
            if (cfg_last) begin
              state      <= S_RUN;
              configured <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (cfg_we && cfg_last) begin
            state      <= S_RUN;
            configured <= 1'b1;
          end
        end
        S_RUN: begin
          if (cfg_we) begin
            if (pipe_empty) begin
              if (!cfg_last) state <= S_LOAD;
            end else begin
              state       <= S_DRAIN;
              pend_valid  <= 1'b1;
              pend_neuron <= cfg_neuron;
              pend_addr   <= cfg_addr;
              pend_data   <= cfg_data;
              pend_last   <= cfg_last;
            end
          end
        end
        S_DRAIN: begin
          // Further writes here are dropped; the pending one commits on exit.
          if (pipe_empty) begin
            pend_valid <= 1'b0;
            state      <= pend_last ? S_RUN : S_LOAD;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Two-stage evaluation pipeline with backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (s1_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) out_data <= rd_out;
      end
      if (!s1_valid || s1_advance) begin
        s1_valid <= in_fire;
        if (in_fire) s1_data <= in_data;
      end
    end
  end

endmodule
